ex_exec_unit: RTL and testbench
===============================

// Module: ex_exec_unit
// PURPOSE
//  Execute-stage datapath core of the 5-stage MIPS pipeline, with three functions:
//  - 32-bit ALU.
//  - Branch-condition evaluator.
//  - Data-memory access launcher: store alignment, byte enables, bridge request.
//  Sits after operand forwarding in EX. The memory request issues in EX; the aligned
//  load result (dm_out) is registered and valid in the next cycle (MEM stage).
// PARAMETERS
//  none. Widths are fixed at 32-bit data/address, 4-bit ALU op, 3-bit branch type.
// PORTS
//  clk          in   1   clock, rising edge
//  rst          in   1   asynchronous, active-low reset
//  rd1          in   32  forwarded rs operand (ALU A, branch lhs)
//  rd2          in   32  forwarded rt operand (ALU B when alu_src=0, branch rhs, store data)
//  ext_b        in   32  extended immediate (ALU B when alu_src=1)
//  alu_src      in   1   1: B=ext_b, 0: B=rd2
//  alu_op       in   4   operation, ex_pkg::aluop_e
//  sa           in   5   shift amount (instr[10:6])
//  branch_type  in   3   ex_pkg::brtype_e
//  mem_write    in   1   store request
//  is_byte      in   1   byte access
//  is_half      in   1   halfword access (is_byte has priority)
//  ld_unsigned  in   1   zero-extend load (else sign-extend)
//  alu_c        out  32  ALU result
//  alu_sum      out  32  A+B always (memory address)
//  alu_zero     out  1   alu_c==0
//  branch_avail out  1   branch condition true
//  br_addr      out  32  {alu_sum[31:2],2'b00} word-aligned bridge address
//  br_we        out  1   = mem_write
//  br_be        out  4   byte enables
//  br_wdata     out  32  lane-replicated store data
//  br_rdata     in   32  read word, returned one cycle after br_addr
//  dm_out       out  32  aligned/extended load data
// BEHAVIOUR
//  - ALU, combinational, A=rd1. Ops:
//    0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR
//    6 SLL B<<sa, 7 SRL B>>sa, 8 SRA B>>>sa
//    9 SLLV B<<A[4:0], 10 SRLV, 11 SRAV
//    12 LUI {B[15:0],16'h0}, 13 PASSB (C=B)
//    14,15: C=0
//  - Arithmetic wraps mod 2^32 with no overflow trap. SUB sign bit is used by EX for SLT.
//  - Branch, combinational, signed compare of rd1 vs rd2 or 0:
//    0 NONE -> 0; 1 BEQ rd1==rd2; 2 BNE rd1!=rd2; 3 BLEZ rd1<=0
//    4 BGTZ rd1>0; 5 BLTZ rd1<0; 6 BGEZ rd1>=0; 7 JUMP -> 1
//  - Store byte enables and data (combinational), off=alu_sum[1:0]:
//    byte: be=4'b0001<<off, wdata={4{rd2[7:0]}}
//    half: be=off[1]?4'b1100:4'b0011, wdata={2{rd2[15:0]}}; off[0] ignored
//    word: be=4'b1111, wdata=rd2; off ignored
//  - br_be is driven on loads too; br_we=0 then.
//  - Load path: on posedge clk, register off, is_byte, is_half, ld_unsigned.
//  - Next cycle dm_out selects the lane from br_rdata with the registered off:
//    byte: br_rdata[8*off+:8]; half: [16*off[1]+:16]; word: full.
//    Byte/half are then zero- or sign-extended per ld_unsigned.
//  - dm_out is valid exactly 1 cycle after the request, with no stall handshake.
//    Back-to-back accesses are allowed every cycle.
//  - Reset (rst=0, async): registered off/flags clear to 0, i.e. word mode.
//    dm_out then shows br_rdata unmodified. Combinational outputs are unaffected by reset.
// STRUCTURE
//  - ex_pkg: aluop_e and brtype_e enums with the encodings above.
//  - Sub-module ex_alu: pure combinational ALU with the ports above.
//  - Branch compare and access alignment logic live inline in ex_exec_unit.
// TESTING
//  - ALU: A=0xFFFFFFFF, B=1, ADD -> C=0, zero=1.
//    SRA B=0x80000000 sa=4 -> 0xF8000000.
//    LUI ext_b=0x1234 alu_src=1 -> 0x12340000.
//  - Branch: rd1=-1, BLEZ -> 1; BGTZ -> 0; BEQ rd1=rd2=5 -> 1; type 0 -> 0; type 7 -> 1.
//  - Store byte: rd1=0x100, ext_b=3, alu_src=1, SB rd2=0xAB
//    -> br_addr=0x100, be=1000, wdata=0xABABABAB.
//  - Store half: SH at off=2 -> be=1100.
//  - Load: LB off=1 with br_rdata=0x0000_8000 next cycle -> dm_out=0xFFFFFF80.
//    Same with ld_unsigned=1 -> 0x00000080.
//    LH off=2 with rdata 0x7FFF0000 -> 0x00007FFF.
//  - Reset: assert rst=0 mid-load -> flags cleared; dm_out=br_rdata raw.
//    Back-to-back LB then LW return correctly aligned in consecutive cycles.

Source files
------------

// File: rtl/ex_pkg.sv
// Shared encodings for the execute stage.
// ALU operations and branch condition types.
package ex_pkg;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_XOR   = 4'd4,
    ALU_NOR   = 4'd5,
    ALU_SLL   = 4'd6,
    ALU_SRL   = 4'd7,
    ALU_SRA   = 4'd8,
    ALU_SLLV  = 4'd9,
    ALU_SRLV  = 4'd10,
    ALU_SRAV  = 4'd11,
    ALU_LUI   = 4'd12,
    ALU_PASSB = 4'd13
  } aluop_e;

  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BR_BEQ  = 3'd1,
    BR_BNE  = 3'd2,
    BR_BLEZ = 3'd3,
    BR_BGTZ = 3'd4,
    BR_BLTZ = 3'd5,
    BR_BGEZ = 3'd6,
    BR_JUMP = 3'd7
  } brtype_e;

endpackage

// File: rtl/ex_alu.sv
// Combinational 32-bit ALU for the execute stage.
// Sum output is always A+B so it can serve as the memory address.
module ex_alu
  import ex_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [4:0]  sa,
  input  logic [3:0]  op,
  output logic [31:0] c,
  output logic [31:0] sum,
  output logic        zero
);

  logic [4:0] w_vsa;

  assign w_vsa = a[4:0];
  assign sum   = a + b;
  assign zero  = (c == 32'h0);

  always_comb begin
    c = 32'h0;
    case (op)
      ALU_ADD:   c = sum;
      ALU_SUB:   c = a - b;
      ALU_AND:   c = a & b;
      ALU_OR:    c = a | b;
      ALU_XOR:   c = a ^ b;
      ALU_NOR:   c = ~(a | b);
      ALU_SLL:   c = b << sa;
      ALU_SRL:   c = b >> sa;
      ALU_SRA:   c = $unsigned($signed(b) >>> sa);
      ALU_SLLV:  c = b << w_vsa;
      ALU_SRLV:  c = b >> w_vsa;
      ALU_SRAV:  c = $unsigned($signed(b) >>> w_vsa);
      ALU_LUI:   c = {b[15:0], 16'h0};
      ALU_PASSB: c = b;
      default:   c = 32'h0;
    endcase
  end

endmodule

// File: rtl/ex_exec_unit.sv
// Execute-stage core: ALU, branch condition and memory access launch.
// Load lane selection uses access attributes registered at issue.
module ex_exec_unit
  import ex_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] rd1,
  input  logic [31:0] rd2,
  input  logic [31:0] ext_b,
  input  logic        alu_src,
  input  logic [3:0]  alu_op,
  input  logic [4:0]  sa,
  input  logic [2:0]  branch_type,
  input  logic        mem_write,
  input  logic        is_byte,
  input  logic        is_half,
  input  logic        ld_unsigned,
  output logic [31:0] alu_c,
  output logic [31:0] alu_sum,
  output logic        alu_zero,
  output logic        branch_avail,
  output logic [31:0] br_addr,
  output logic        br_we,
  output logic [3:0]  br_be,
  output logic [31:0] br_wdata,
  input  logic [31:0] br_rdata,
  output logic [31:0] dm_out
);

  logic [31:0] w_b;
  logic [1:0]  w_off;
  logic        w_neg;
  logic        w_z;
  logic [7:0]  w_lbyte;
  logic [15:0] w_lhalf;
  logic [1:0]  r_off;
  logic        r_byte;
  logic        r_half;
  logic        r_uns;

  assign w_b = alu_src ? ext_b : rd2;

  ex_alu u_alu (
    .a    (rd1),
    .b    (w_b),
    .sa   (sa),
    .op   (alu_op),
    .c    (alu_c),
    .sum  (alu_sum),
    .zero (alu_zero)
  );

  assign w_neg = rd1[31];
  assign w_z   = (rd1 == 32'h0);

  always_comb begin
    branch_avail = 1'b0;
    case (branch_type)
      BR_NONE: branch_avail = 1'b0;
      BR_BEQ:  branch_avail = (rd1 == rd2);
      BR_BNE:  branch_avail = (rd1 != rd2);
      BR_BLEZ: branch_avail = w_neg | w_z;
      BR_BGTZ: branch_avail = ~w_neg & ~w_z;
      BR_BLTZ: branch_avail = w_neg;
      BR_BGEZ: branch_avail = ~w_neg;
      BR_JUMP: branch_avail = 1'b1;
      default: branch_avail = 1'b0;
    endcase
  end

  assign w_off   = alu_sum[1:0];
  assign br_addr = {alu_sum[31:2], 2'b00};
  assign br_we   = mem_write;

  // is_byte wins over is_half; word accesses ignore the offset
  always_comb begin
    if (is_byte) begin
      br_be    = 4'b0001 << w_off;
      br_wdata = {4{rd2[7:0]}};
    end else if (is_half) begin
      br_be    = w_off[1] ? 4'b1100 : 4'b0011;
      br_wdata = {2{rd2[15:0]}};
    end else begin
      br_be    = 4'b1111;
      br_wdata = rd2;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_off  <= 2'b00;
      r_byte <= 1'b0;
      r_half <= 1'b0;
      r_uns  <= 1'b0;
    end else begin
      r_off  <= w_off;
      r_byte <= is_byte;
      r_half <= is_half;
      r_uns  <= ld_unsigned;
    end
  end

  always_comb begin
    w_lbyte = br_rdata[7:0];
    case (r_off)
      2'd0:    w_lbyte = br_rdata[7:0];
      2'd1:    w_lbyte = br_rdata[15:8];
      2'd2:    w_lbyte = br_rdata[23:16];
      default: w_lbyte = br_rdata[31:24];
    endcase
  end

  assign w_lhalf = r_off[1] ? br_rdata[31:16] : br_rdata[15:0];

  always_comb begin
    if (r_byte)
      dm_out = {{24{~r_uns & w_lbyte[7]}}, w_lbyte};
    else if (r_half)
      dm_out = {{16{~r_uns & w_lhalf[15]}}, w_lhalf};
    else
      dm_out = br_rdata;
  end

endmodule

// File: tb/tb_ex_exec_unit.sv
// Directed bench for ex_exec_unit: vector table for the
// combinational paths, hand sequences for the registered load path.
module tb_ex_exec_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] rd1, rd2, ext_b;
  logic        alu_src;
  logic [3:0]  alu_op;
  logic [4:0]  sa;
  logic [2:0]  branch_type;
  logic        mem_write, is_byte, is_half, ld_unsigned;
  logic [31:0] alu_c, alu_sum;
  logic        alu_zero, branch_avail;
  logic [31:0] br_addr;
  logic        br_we;
  logic [3:0]  br_be;
  logic [31:0] br_wdata, br_rdata, dm_out;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ex_exec_unit dut (
    .clk          (clk),
    .rst          (rst),
    .rd1          (rd1),
    .rd2          (rd2),
    .ext_b        (ext_b),
    .alu_src      (alu_src),
    .alu_op       (alu_op),
    .sa           (sa),
    .branch_type  (branch_type),
    .mem_write    (mem_write),
    .is_byte      (is_byte),
    .is_half      (is_half),
    .ld_unsigned  (ld_unsigned),
    .alu_c        (alu_c),
    .alu_sum      (alu_sum),
    .alu_zero     (alu_zero),
    .branch_avail (branch_avail),
    .br_addr      (br_addr),
    .br_we        (br_we),
    .br_be        (br_be),
    .br_wdata     (br_wdata),
    .br_rdata     (br_rdata),
    .dm_out       (dm_out)
  );

  typedef struct {
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] ext_b;
    logic        src;
    logic [3:0]  op;
    logic [4:0]  sa;
    logic [2:0]  bt;
    logic        mw;
    logic        ib;
    logic        ih;
    logic [31:0] c;
    logic        z;
    logic        br;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
  } vec_t;

  vec_t v[16];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle();
    rd1 = 32'h0; rd2 = 32'h0; ext_b = 32'h0;
    alu_src = 1'b0; alu_op = 4'd0; sa = 5'd0;
    branch_type = 3'd0; mem_write = 1'b0;
    is_byte = 1'b0; is_half = 1'b0; ld_unsigned = 1'b0;
  endtask

  task automatic ld_req(input logic [31:0] base, input logic [31:0] ofs,
                        input logic b, input logic h, input logic u);
    idle();
    rd1 = base; ext_b = ofs; alu_src = 1'b1;
    is_byte = b; is_half = h; ld_unsigned = u;
  endtask

  initial begin
    v[0]  = '{32'hFFFFFFFF, 32'h1, 32'h0, 1'b0, 4'd0, 5'd0, 3'd0,
              1'b0, 1'b0, 1'b0,
              32'h0, 1'b1, 1'b0, 32'h0, 4'hF, 32'h1};
    v[1]  = '{32'h0, 32'h80000000, 32'h0, 1'b0, 4'd8, 5'd4, 3'd0,
              1'b0, 1'b0, 1'b0,
              32'hF8000000, 1'b0, 1'b0, 32'h80000000, 4'hF, 32'h80000000};
    v[2]  = '{32'h0, 32'h0, 32'h1234, 1'b1, 4'd12, 5'd0, 3'd0,
              1'b0, 1'b0, 1'b0,
              32'h12340000, 1'b0, 1'b0, 32'h1234, 4'hF, 32'h0};
    v[3]  = '{32'hFFFFFFFF, 32'h0, 32'h0, 1'b0, 4'd0, 5'd0, 3'd3,
              1'b0, 1'b0, 1'b0,
              32'hFFFFFFFF, 1'b0, 1'b1, 32'hFFFFFFFC, 4'hF, 32'h0};
    v[4]  = '{32'hFFFFFFFF, 32'h0, 32'h0, 1'b0, 4'd0, 5'd0, 3'd4,
              1'b0, 1'b0, 1'b0,
              32'hFFFFFFFF, 1'b0, 1'b0, 32'hFFFFFFFC, 4'hF, 32'h0};
    v[5]  = '{32'h5, 32'h5, 32'h0, 1'b0, 4'd1, 5'd0, 3'd1,
              1'b0, 1'b0, 1'b0,
              32'h0, 1'b1, 1'b1, 32'h8, 4'hF, 32'h5};
    v[6]  = '{32'h5, 32'h5, 32'h0, 1'b0, 4'd2, 5'd0, 3'd7,
              1'b0, 1'b0, 1'b0,
              32'h5, 1'b0, 1'b1, 32'h8, 4'hF, 32'h5};
    v[7]  = '{32'h100, 32'hAB, 32'h3, 1'b1, 4'd0, 5'd0, 3'd0,
              1'b1, 1'b1, 1'b0,
              32'h103, 1'b0, 1'b0, 32'h100, 4'b1000, 32'hABABABAB};
    v[8]  = '{32'h200, 32'h1234CDEF, 32'h2, 1'b1, 4'd0, 5'd0, 3'd0,
              1'b1, 1'b0, 1'b1,
              32'h202, 1'b0, 1'b0, 32'h200, 4'b1100, 32'hCDEFCDEF};
    v[9]  = '{32'h3, 32'h4, 32'h0, 1'b0, 4'd3, 5'd0, 3'd2,
              1'b0, 1'b0, 1'b0,
              32'h7, 1'b0, 1'b1, 32'h4, 4'hF, 32'h4};
    v[10] = '{32'h0, 32'h0, 32'h0, 1'b0, 4'd5, 5'd0, 3'd5,
              1'b0, 1'b0, 1'b0,
              32'hFFFFFFFF, 1'b0, 1'b0, 32'h0, 4'hF, 32'h0};
    v[11] = '{32'h24, 32'h1, 32'h0, 1'b0, 4'd9, 5'd0, 3'd6,
              1'b0, 1'b0, 1'b0,
              32'h10, 1'b0, 1'b1, 32'h24, 4'hF, 32'h1};
    v[12] = '{32'h1, 32'h2, 32'h0, 1'b0, 4'd14, 5'd0, 3'd6,
              1'b0, 1'b0, 1'b0,
              32'h0, 1'b1, 1'b1, 32'h0, 4'hF, 32'h2};
    v[13] = '{32'h1F, 32'h80000000, 32'h0, 1'b0, 4'd11, 5'd0, 3'd0,
              1'b0, 1'b1, 1'b0,
              32'hFFFFFFFF, 1'b0, 1'b0, 32'h8000001C, 4'b1000, 32'h0};
    v[14] = '{32'h11, 32'h0000BEEF, 32'h0, 1'b1, 4'd0, 5'd0, 3'd0,
              1'b1, 1'b0, 1'b1,
              32'h11, 1'b0, 1'b0, 32'h10, 4'b0011, 32'hBEEFBEEF};
    v[15] = '{32'h0, 32'h80000000, 32'h0, 1'b0, 4'd7, 5'd31, 3'd0,
              1'b0, 1'b0, 1'b0,
              32'h1, 1'b0, 1'b0, 32'h80000000, 4'hF, 32'h80000000};

    idle();
    br_rdata = 32'h0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    br_rdata = 32'h12345680;
    #1 chk("reset dm_out raw", dm_out, 32'h12345680);
    rst = 1'b1;

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      rd1 = v[i].rd1; rd2 = v[i].rd2; ext_b = v[i].ext_b;
      alu_src = v[i].src; alu_op = v[i].op; sa = v[i].sa;
      branch_type = v[i].bt; mem_write = v[i].mw;
      is_byte = v[i].ib; is_half = v[i].ih; ld_unsigned = 1'b0;
      #2;
      chk($sformatf("v%0d alu_c", i), alu_c, v[i].c);
      chk($sformatf("v%0d zero", i), {31'h0, alu_zero}, {31'h0, v[i].z});
      chk($sformatf("v%0d branch", i), {31'h0, branch_avail},
          {31'h0, v[i].br});
      chk($sformatf("v%0d br_addr", i), br_addr, v[i].addr);
      chk($sformatf("v%0d br_be", i), {28'h0, br_be}, {28'h0, v[i].be});
      chk($sformatf("v%0d br_wdata", i), br_wdata, v[i].wd);
      chk($sformatf("v%0d br_we", i), {31'h0, br_we}, {31'h0, v[i].mw});
    end

    // LB signed, off=1
    @(negedge clk); ld_req(32'h1000, 32'h1, 1'b1, 1'b0, 1'b0);
    @(negedge clk); idle(); br_rdata = 32'h00008000;
    #1 chk("LB signed", dm_out, 32'hFFFFFF80);

    // LBU, off=1
    @(negedge clk); ld_req(32'h1000, 32'h1, 1'b1, 1'b0, 1'b1);
    @(negedge clk); idle(); br_rdata = 32'h00008000;
    #1 chk("LBU", dm_out, 32'h00000080);

    // LH off=2, positive then negative
    @(negedge clk); ld_req(32'h2000, 32'h2, 1'b0, 1'b1, 1'b0);
    @(negedge clk); idle(); br_rdata = 32'h7FFF0000;
    #1 chk("LH pos", dm_out, 32'h00007FFF);
    @(negedge clk); ld_req(32'h2000, 32'h2, 1'b0, 1'b1, 1'b0);
    @(negedge clk); idle(); br_rdata = 32'h80010000;
    #1 chk("LH neg", dm_out, 32'hFFFF8001);

    // back-to-back LB (off=3) then LW
    @(negedge clk); ld_req(32'h3000, 32'h3, 1'b1, 1'b0, 1'b0);
    @(negedge clk); ld_req(32'h3004, 32'h0, 1'b0, 1'b0, 1'b0);
    br_rdata = 32'h7F000000;
    #1 chk("b2b LB", dm_out, 32'h0000007F);
    @(negedge clk); idle(); br_rdata = 32'hDEADBEEF;
    #1 chk("b2b LW", dm_out, 32'hDEADBEEF);

    // reset while a signed byte load is pending
    @(negedge clk); ld_req(32'h1000, 32'h1, 1'b1, 1'b0, 1'b0);
    @(negedge clk); idle(); br_rdata = 32'h00008000;
    rst = 1'b0;
    #1 chk("reset mid-load", dm_out, 32'h00008000);
    @(negedge clk); rst = 1'b1;
    #1 chk("after reset", dm_out, 32'h00008000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
